uart_tx_engine: RTL and testbench
=================================

# uart_tx_engine

Serial transmitter of the UART 16550 core. It drains the TX FIFO that the register file fills through `tx_push_o`, and shifts each character out LSB-first with start, parity and stop bits. Character framing comes from the LCR fields of `csr`, and bit timing comes from the 16x `baud_out` pulse. It sits between the TX FIFO and the `tx` pad, and reports `temt_o` back to LSR.

## Interface
- No parameters. Oversample ratio is fixed at 16.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `baud_pulse_i` in 1: single-cycle 16x baud tick from the register file's `baud_out`.
- `lcr_i` in `lcr_t`: line control. Fields are `wls[1:0]`, `stb`, `pen`, `eps`, `sp`, `bc`, `dlab`.
- `fifo_empty_i` in 1: TX FIFO empty.
- `fifo_dout_i` in 8: TX FIFO head. Show-ahead, so it is valid whenever `!fifo_empty_i`.
- `fifo_pop_o` out 1: single-cycle pop strobe.
- `tx_o` out 1: serial line. Idles high.
- `busy_o` out 1: a frame is in progress (state is not IDLE).
- `temt_o` out 1: transmitter empty, equal to `fifo_empty_i & ~busy_o`.

## Operation
- States are IDLE, START, DATA, PARITY, STOP.
- IDLE
  - `tx_o` = 1.
  - If `!fifo_empty_i`, assert `fifo_pop_o` for 1 cycle.
  - In the same edge, capture `fifo_dout_i` into the shift register and latch `wls`, `stb`, `pen`, `eps`, `sp`.
  - Clear the tick and bit counters, then go to START.
- Latched framing applies to the whole frame. LCR writes take effect on the next frame only.
- Every bit lasts 16 `baud_pulse_i` ticks. The tick counter is 4 bits and increments only on `baud_pulse_i`.
- START: `tx_o` = 0. After 16 ticks go to DATA.
- DATA
  - `tx_o` = `shift[0]`.
  - Every 16 ticks, shift right and increment the bit counter.
  - After `wls+5` bits go to PARITY if `pen` is set, otherwise to STOP.
- PARITY: the parity bit is computed over the `wls+5` data bits only. Hold it for 16 ticks, then go to STOP.
  - `sp`=1: bit = `~eps`.
  - `sp`=0, `eps`=1 (even): bit = XOR of the data bits.
  - `sp`=0, `eps`=0 (odd): bit = XNOR of the data bits.
- STOP: `tx_o` = 1. Duration depends on `stb` and `wls`, then go to IDLE.
  - `stb`=0: 16 ticks.
  - `stb`=1, `wls`=0: 24 ticks.
  - `stb`=1, other `wls`: 32 ticks.
- Break
  - While `lcr_i.bc`=1 (live, not latched), `tx_o` is forced to 0.
  - The state machine keeps running and FIFO popping continues.
  - Releasing `bc` restores the normal line value in the next cycle.
- `dlab` has no effect on this block.

## Timing
- Reset values: `tx_o`=1, `fifo_pop_o`=0, `busy_o`=0, state=IDLE, counters=0. `temt_o` = `fifo_empty_i`.
- Pop to line: `tx_o` falls 1 cycle after the `fifo_pop_o` cycle.
- All of `tx_o` is driven from a register (no glitches). Break forcing is the one exception: it is an AND with `~bc` in that register's next-state logic, so it is also registered.
- Back-to-back frames: the cycle STOP ends, the FSM is in IDLE. It pops on that IDLE cycle when the FIFO is non-empty. The inter-frame gap is at most 2 clk, and no idle bit is inserted.
- FIFO empty in IDLE: no pop. Stay in IDLE with `tx_o`=1.
- `fifo_pop_o` is never asserted outside IDLE, and never when `fifo_empty_i`=1.
- Reset mid-frame: outputs go to reset values immediately. The frame is lost and nothing is re-popped.
- `baud_pulse_i` absent: the FSM stalls in its current state holding `tx_o`.
- Frame length in ticks = 16·(1 + `wls`+5 + `pen`) + stop ticks.

## Structure
- Shared package `uart_pkg` holds:
  - `lcr_t` (packed LCR fields, already used by `csr_t`).
  - `tx_state_e` enum (IDLE, START, DATA, PARITY, STOP).
  - Constant `OVERSAMPLE` = 16.
- No sub-module. The FSM, counters, shift register and parity sit in one module.

## Test plan
- 8N1 (`lcr`=0x03), one byte 0x55, `baud_pulse_i` every cycle.
  - One `fifo_pop_o`.
  - `tx_o` = 0,1,0,1,0,1,0,1,0,1, each held 16 clk.
  - Frame is 160 clk, then `temt_o`=1.
- 7E1 (`lcr`=0x1A), byte 0x41: data 1,0,0,0,0,0,1, then parity 0, then one stop. Total 160 clk.
- 5-bit, `stb`=1, no parity (`lcr`=0x04), byte 0x1F: five 1s after the start bit. Stop lasts 24 clk, frame 120 clk.
- Stick parity `lcr`=0x2B (8 bits, `pen`, `sp`, odd) on 0xFF: parity bit 1.
  - Re-run with `eps`=1 (`lcr`=0x3B): parity bit 0.
- Back-to-back with break.
  - Two bytes 0xA5, 0x3C preloaded: second pop occurs ≤2 clk after the first stop ends, with no extra idle.
  - Set `bc`=1 during the second byte's data: `tx_o`=0 while set, and the frame still completes on time.
- Reset mid-frame.
  - `rst`=0 during a DATA bit: `tx_o`=1, `busy_o`=0, `fifo_pop_o`=0 in the same cycle.
  - After release with the FIFO non-empty, the next pop occurs on the first IDLE cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART 16550 types: line-control register layout, transmitter states
// and the parity helper used when a character is taken from the TX FIFO.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int TICK_W     = $clog2(OVERSAMPLE);

  // Field order matches the LCR bit layout, dlab in bit 7 down to wls in bits 1:0.
  typedef struct packed {
    logic       dlab;
    logic       bc;
    logic       sp;
    logic       eps;
    logic       pen;
    logic       stb;
    logic [1:0] wls;
  } lcr_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // Framing held for the duration of one character.
  typedef struct packed {
    logic [1:0] wls;
    logic       stb;
    logic       pen;
  } frame_cfg_t;

  function automatic logic [7:0] data_mask(input logic [1:0] wls);
    logic [7:0] mask;
    case (wls)
      2'd0:    mask = 8'h1F;
      2'd1:    mask = 8'h3F;
      2'd2:    mask = 8'h7F;
      default: mask = 8'hFF;
    endcase
    return mask;
  endfunction

  // Stick parity sends ~eps; otherwise even parity is the XOR of the data
  // bits and odd parity its complement, so XOR-ing with ~eps covers both.
  function automatic logic parity_bit(input logic [7:0] data, input lcr_t lcr);
    logic par;
    if (lcr.sp) par = ~lcr.eps;
    else        par = (^(data & data_mask(lcr.wls))) ^ ~lcr.eps;
    return par;
  endfunction

endpackage

// File: rtl/uart_tx_engine_if.sv
// TX FIFO read port: show-ahead head, empty flag and a single-cycle pop strobe.
interface uart_tx_engine_if;

  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       fifo_pop;

  modport master (
    input  fifo_empty,
    input  fifo_dout,
    output fifo_pop
  );

  modport slave (
    output fifo_empty,
    output fifo_dout,
    input  fifo_pop
  );

endinterface

// File: rtl/uart_tx_engine.sv
// UART transmitter: drains the TX FIFO and serialises each character as
// start, 5..8 data bits LSB-first, optional parity and 1/1.5/2 stop bits.
module uart_tx_engine
  import uart_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               baud_pulse_i,
  input  lcr_t               lcr_i,
  uart_tx_engine_if.master   fifo,
  output logic               tx_o,
  output logic               busy_o,
  output logic               temt_o
);

  tx_state_e         state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  frame_cfg_t        cfg_q, cfg_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;

  logic              pop;
  logic              tick_done;
  logic              stop_done;
  logic              line;
  logic [2:0]        last_bit;

  // Divisor-latch access is a register-file concern only.
  logic              lcr_unused;
  assign lcr_unused = lcr_i.dlab;

  assign tick_done = baud_pulse_i && (tick_q == TICK_W'(OVERSAMPLE - 1));
  assign last_bit  = {1'b0, cfg_q.wls} + 3'd4;

  // 1.5 stop bits end half-way through the second bit period.
  always_comb begin
    stop_done = 1'b0;
    if (!cfg_q.stb)              stop_done = tick_done;
    else if (cfg_q.wls == 2'd0)  stop_done = baud_pulse_i && (bit_q == 3'd1) &&
                                             (tick_q == TICK_W'(OVERSAMPLE / 2 - 1));
    else                         stop_done = tick_done && (bit_q == 3'd1);
  end

  // NOTE: every next-state signal is defaulted to its current value before the
  // case, so no path through this block leaves a signal unassigned (no latches).
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    cfg_d   = cfg_q;
    par_d   = par_q;
    pop     = 1'b0;

    if (state_q != IDLE && baud_pulse_i) tick_d = tick_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (!fifo.fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo.fifo_dout;
          cfg_d   = '{wls: lcr_i.wls, stb: lcr_i.stb, pen: lcr_i.pen};
          par_d   = parity_bit(fifo.fifo_dout, lcr_i);
          tick_d  = '0;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (tick_done) state_d = DATA;
      end
      DATA: begin
        if (tick_done) begin
          shift_d = shift_q >> 1;
          if (bit_q == last_bit) begin
            bit_d   = '0;
            state_d = cfg_q.pen ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (tick_done) state_d = STOP;
      end
      STOP: begin
        if (stop_done) begin
          tick_d  = '0;
          bit_d   = '0;
          state_d = IDLE;
        end else if (tick_done) begin
          bit_d = bit_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line value for the state being entered, so tx_o is registered and
  // changes on the same edge as the state.
  always_comb begin
    line = 1'b1;
    case (state_d)
      IDLE:    line = 1'b1;
      START:   line = 1'b0;
      DATA:    line = shift_d[0];
      PARITY:  line = par_d;
      STOP:    line = 1'b1;
      default: line = 1'b1;
    endcase
    tx_d = line & ~lcr_i.bc;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      cfg_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      cfg_q   <= cfg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  // Reset forces IDLE, where a non-empty FIFO would otherwise raise pop;
  // gating with rst keeps the strobe low while reset is held.
  assign fifo.fifo_pop = pop & rst;
  assign tx_o          = tx_q;
  assign busy_o        = (state_q != IDLE);
  assign temt_o        = fifo.fifo_empty & ~busy_o;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: framing variants, stall, break,
// back-to-back characters and reset mid-frame against a small FIFO model.
module tb_uart_tx_engine;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic baud;
  lcr_t lcr;
  logic tx, busy, temt;

  uart_tx_engine_if fifo ();

  logic [7:0] mem [16];
  int wr_idx = 0;
  int rd_idx = 0;
  int n_checks = 0;
  int n_errors = 0;
  int cur = 0;

  always #5 clk = ~clk;

  assign fifo.fifo_empty = (rd_idx == wr_idx);
  assign fifo.fifo_dout  = mem[rd_idx[3:0]];

  always @(posedge clk) if (fifo.fifo_pop === 1'b1) rd_idx <= rd_idx + 1;

  uart_tx_engine dut (
    .clk          (clk),
    .rst          (rst),
    .baud_pulse_i (baud),
    .lcr_i        (lcr),
    .fifo         (fifo),
    .tx_o         (tx),
    .busy_o       (busy),
    .temt_o       (temt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic goto(input int c);
    while (cur < c) begin
      @(negedge clk);
      cur++;
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_idx[3:0]] = b;
    wr_idx++;
  endtask

  task automatic wait_pop(input string tag);
    int n = 0;
    #1;
    while (fifo.fifo_pop !== 1'b1 && n < 64) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(tag, {31'd0, fifo.fifo_pop}, 32'd1);
    cur = 0;
  endtask

  // bits[0] is the start bit, followed by data and optional parity.
  task automatic run_frame(input string tag, input logic [15:0] bits, input int nbits,
                           input int stop, input logic exp_temt);
    wait_pop({tag, "_pop"});
    for (int k = 0; k < nbits; k++) begin
      goto(1 + 16 * k);
      check($sformatf("%s_b%0d_first", tag, k), {31'd0, tx}, {31'd0, bits[k]});
      goto(16 + 16 * k);
      check($sformatf("%s_b%0d_last", tag, k), {31'd0, tx}, {31'd0, bits[k]});
    end
    goto(16 * nbits + 1);
    check({tag, "_stop_first"}, {31'd0, tx}, 32'd1);
    goto(16 * nbits + stop);
    check({tag, "_stop_last"}, {31'd0, tx}, 32'd1);
    check({tag, "_busy_end"}, {31'd0, busy}, 32'd1);
    goto(16 * nbits + stop + 1);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    check({tag, "_temt"}, {31'd0, temt}, {31'd0, exp_temt});
  endtask

  initial begin
    rst  = 1'b0;
    baud = 1'b1;
    lcr  = lcr_t'(8'h03);
    repeat (3) @(negedge clk);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_pop", {31'd0, fifo.fifo_pop}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_temt", {31'd0, temt}, 32'd1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_tx", {31'd0, tx}, 32'd1);
    check("idle_pop", {31'd0, fifo.fifo_pop}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // 8N1, 0x55
    lcr = lcr_t'(8'h03);
    push(8'h55);
    run_frame("8n1", {7'd0, 8'h55, 1'b0}, 9, 16, 1'b1);

    // 7E1, 0x41: parity over 7 data bits is 0
    lcr = lcr_t'(8'h1A);
    push(8'h41);
    run_frame("7e1", {7'd0, 1'b0, 7'h41, 1'b0}, 9, 16, 1'b1);

    // 5 bits, 1.5 stop bits, 0x1F
    lcr = lcr_t'(8'h04);
    push(8'h1F);
    run_frame("5n15", {10'd0, 5'h1F, 1'b0}, 6, 24, 1'b1);

    // Stick parity with eps=0 sends 1, with eps=1 sends 0
    lcr = lcr_t'(8'h2B);
    push(8'hFF);
    run_frame("stick1", {6'd0, 1'b1, 8'hFF, 1'b0}, 10, 16, 1'b1);
    lcr = lcr_t'(8'h3B);
    push(8'hFF);
    run_frame("stick0", {6'd0, 1'b0, 8'hFF, 1'b0}, 10, 16, 1'b1);

    // Back-to-back 0xA5, 0x3C with break during the second character
    lcr = lcr_t'(8'h03);
    push(8'hA5);
    push(8'h3C);
    run_frame("b2b1", {7'd0, 8'hA5, 1'b0}, 9, 16, 1'b0);
    check("b2b_gap_pop", {31'd0, fifo.fifo_pop}, 32'd1);
    wait_pop("b2b2_pop");
    goto(1);
    check("b2b2_start", {31'd0, tx}, 32'd0);
    goto(66);
    lcr.bc = 1'b1;
    goto(67);
    check("brk_bit3", {31'd0, tx}, 32'd0);
    goto(90);
    check("brk_bit4", {31'd0, tx}, 32'd0);
    goto(100);
    check("brk_bit5", {31'd0, tx}, 32'd0);
    lcr.bc = 1'b0;
    goto(101);
    check("brk_release", {31'd0, tx}, 32'd1);
    goto(120);
    check("b2b2_bit6", {31'd0, tx}, 32'd0);
    goto(160);
    check("b2b2_stop_tx", {31'd0, tx}, 32'd1);
    check("b2b2_busy_end", {31'd0, busy}, 32'd1);
    goto(161);
    check("b2b2_idle", {31'd0, busy}, 32'd0);
    check("b2b2_temt", {31'd0, temt}, 32'd1);

    // Baud ticks withheld: the start bit stretches until they resume
    baud = 1'b0;
    push(8'h00);
    wait_pop("stall_pop");
    goto(30);
    check("stall_tx", {31'd0, tx}, 32'd0);
    check("stall_busy", {31'd0, busy}, 32'd1);
    baud = 1'b1;
    goto(173);
    check("stall_last_data", {31'd0, tx}, 32'd0);
    goto(174);
    check("stall_stop", {31'd0, tx}, 32'd1);
    goto(189);
    check("stall_busy_end", {31'd0, busy}, 32'd1);
    goto(190);
    check("stall_idle", {31'd0, busy}, 32'd0);

    // Reset during a data bit with a second character still queued
    push(8'h12);
    push(8'h34);
    wait_pop("mid_pop");
    goto(40);
    rst = 1'b0;
    #1;
    check("mid_rst_tx", {31'd0, tx}, 32'd1);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_pop", {31'd0, fifo.fifo_pop}, 32'd0);
    goto(42);
    rst = 1'b1;
    #1;
    check("post_rst_pop", {31'd0, fifo.fifo_pop}, 32'd1);
    cur = 0;
    goto(1);
    check("post_rst_start", {31'd0, tx}, 32'd0);
    goto(17);
    check("post_rst_b0", {31'd0, tx}, 32'd0);
    goto(49);
    check("post_rst_b2", {31'd0, tx}, 32'd1);
    goto(160);
    check("post_rst_busy_end", {31'd0, busy}, 32'd1);
    goto(161);
    check("post_rst_idle", {31'd0, busy}, 32'd0);
    check("post_rst_temt", {31'd0, temt}, 32'd1);
    check("total_pops", rd_idx, 32'd10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
